// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
// The arbiter uses the slave view; requesters and memory together use the master view.
interface data_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          r0_req;
    logic          r0_we;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r0_gnt;
    logic          r0_rvalid;
    logic [DW-1:0] r0_rdata;

    logic          r1_req;
    logic          r1_we;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic          r1_gnt;
    logic          r1_rvalid;
    logic [DW-1:0] r1_rdata;

    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic          mem_we;
    logic [DW-1:0] mem_rd;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        output r0_gnt, r0_rvalid, r0_rdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output mem_a, mem_wd, mem_we,
        input  mem_rd
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        input  r0_gnt, r0_rvalid, r0_rdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  mem_a, mem_wd, mem_we,
        output mem_rd
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Each access takes one IDLE -> ACCESS -> RESP slot; dbg_state exposes the FSM encoding.
module data_mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_arbiter_if.slave    bus,
    output logic [1:0]           dbg_state
);

    // Handshake: a requester raises req with we/addr/wdata stable and holds them
    // until the cycle its gnt is high; that gnt cycle is the memory access itself.
    // Reads return rdata with a one-cycle rvalid in the following cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          sel, sel_nxt;
    logic          last, last_nxt;
    logic          is_rd, is_rd_nxt;
    logic [DW-1:0] rdata0, rdata1;
    logic          cap0, cap1;

    logic          win_any;
    logic          win_port;
    logic          win_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // A tie goes to the port that was not granted most recently.
    always_comb begin
        win_any = bus.r0_req | bus.r1_req;
        if (bus.r0_req && bus.r1_req) begin
            win_port = ~last;
        end else begin
            win_port = bus.r1_req;
        end
        win_we = win_port ? bus.r1_we : bus.r0_we;
    end

    always_comb begin
        sel_addr  = sel ? bus.r1_addr  : bus.r0_addr;
        sel_wdata = sel ? bus.r1_wdata : bus.r0_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= 1'b0;
            last  <= 1'b1;
            is_rd <= 1'b0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            last  <= last_nxt;
            is_rd <= is_rd_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sel_nxt       = sel;
        last_nxt      = last;
        is_rd_nxt     = is_rd;
        cap0          = 1'b0;
        cap1          = 1'b0;
        bus.r0_gnt    = 1'b0;
        bus.r1_gnt    = 1'b0;
        bus.r0_rvalid = 1'b0;
        bus.r1_rvalid = 1'b0;
        bus.mem_a     = '0;
        bus.mem_wd    = '0;
        bus.mem_we    = 1'b0;

        case (state)
            IDLE: begin
                if (win_any) begin
                    sel_nxt   = win_port;
                    is_rd_nxt = ~win_we;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                // Memory pins are driven only here, so a reset drops them at once.
                bus.mem_a  = sel_addr;
                bus.mem_wd = sel_wdata;
                bus.mem_we = ~is_rd;
                bus.r0_gnt = ~sel;
                bus.r1_gnt = sel;
                last_nxt   = sel;
                cap0       = is_rd & ~sel;
                cap1       = is_rd & sel;
                state_nxt  = RESP;
            end
            RESP: begin
                bus.r0_rvalid = is_rd & ~sel;
                bus.r1_rvalid = is_rd & sel;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            if (cap0) rdata0 <= bus.mem_rd;
            if (cap1) rdata1 <= bus.mem_rd;
        end
    end

    assign bus.r0_rdata = rdata0;
    assign bus.r1_rdata = rdata1;
    assign dbg_state    = state;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: slot-level reference model, per-cycle compare,
// and literal expectations for each scenario.
module tb_data_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    data_mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    data_mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory behind the arbiter and the model's own view of it.
    logic [31:0] mem    [64];
    logic [31:0] shadow [64];
    bit          mem_init = 1'b0;

    assign bus.mem_rd = mem[bus.mem_a[7:2]];

    // Reference model: each grant is one record; a slot occupies three cycles.
    typedef struct {
        int          gcyc;
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } rec_t;

    rec_t        recs[$];
    int          cyc       = 0;
    int          next_free = 0;
    bit          m_last    = 1'b1;
    logic [31:0] m_rdata [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            if (!mem_init) begin
                for (int i = 0; i < 64; i++) begin
                    mem[i]    <= 32'h0;
                    shadow[i]  = 32'h0;
                end
                mem[0]    <= 32'h11; shadow[0] = 32'h11;
                mem[1]    <= 32'h22; shadow[1] = 32'h22;
                mem[2]    <= 32'h55; shadow[2] = 32'h55;
                mem_init   = 1'b1;
            end
            recs.delete();
            m_rdata[0] = 32'h0;
            m_rdata[1] = 32'h0;
            m_last     = 1'b1;
            next_free  = 0;
        end else begin
            if (bus.mem_we) mem[bus.mem_a[7:2]] <= bus.mem_wd;
            cyc++;
            foreach (recs[i]) begin
                if (recs[i].gcyc == cyc - 1) begin
                    if (recs[i].we) shadow[recs[i].addr[7:2]] = recs[i].wdata;
                    else            m_rdata[recs[i].port]  = shadow[recs[i].addr[7:2]];
                    m_last = recs[i].port;
                end
            end
            while (recs.size() > 0 && recs[0].gcyc < cyc - 1) void'(recs.pop_front());
            if (cyc >= next_free && (bus.r0_req || bus.r1_req)) begin
                rec_t r;
                r.port  = (bus.r0_req && bus.r1_req) ? ~m_last : bus.r1_req;
                r.gcyc  = cyc;
                r.we    = r.port ? bus.r1_we    : bus.r0_we;
                r.addr  = r.port ? bus.r1_addr  : bus.r0_addr;
                r.wdata = r.port ? bus.r1_wdata : bus.r0_wdata;
                recs.push_back(r);
                next_free = cyc + 3;
            end
        end
    end

    // Event log used by the literal checks.
    int gq_cyc[$];
    bit gq_port[$];
    int we_cnt = 0, rv0_cnt = 0, rv1_cnt = 0, g0_cnt = 0;
    int last_rv0 = -1;

    always @(negedge clk) begin
        logic        e_g0, e_g1, e_v0, e_v1, e_we;
        logic [31:0] e_a, e_wd;
        e_g0 = 1'b0; e_g1 = 1'b0; e_v0 = 1'b0; e_v1 = 1'b0; e_we = 1'b0;
        e_a  = 32'h0; e_wd = 32'h0;
        if (bus.r0_gnt) begin gq_cyc.push_back(cyc); gq_port.push_back(1'b0); g0_cnt++; end
        if (bus.r1_gnt) begin gq_cyc.push_back(cyc); gq_port.push_back(1'b1); end
        if (bus.mem_we)    we_cnt++;
        if (bus.r0_rvalid) begin rv0_cnt++; last_rv0 = cyc; end
        if (bus.r1_rvalid) rv1_cnt++;
        if (!rst) begin
            foreach (recs[i]) begin
                if (recs[i].gcyc == cyc) begin
                    if (recs[i].port) e_g1 = 1'b1; else e_g0 = 1'b1;
                    e_we = recs[i].we;
                    e_a  = recs[i].addr;
                    e_wd = recs[i].wdata;
                end
                if (recs[i].gcyc == cyc - 1 && !recs[i].we) begin
                    if (recs[i].port) e_v1 = 1'b1; else e_v0 = 1'b1;
                end
            end
        end
        check("cyc_r0_gnt",    bus.r0_gnt,    e_g0);
        check("cyc_r1_gnt",    bus.r1_gnt,    e_g1);
        check("cyc_r0_rvalid", bus.r0_rvalid, e_v0);
        check("cyc_r1_rvalid", bus.r1_rvalid, e_v1);
        check("cyc_mem_we",    bus.mem_we,    e_we);
        check("cyc_mem_a",     bus.mem_a,     e_a);
        check("cyc_mem_wd",    bus.mem_wd,    e_wd);
        check("cyc_r0_rdata",  bus.r0_rdata,  m_rdata[0]);
        check("cyc_r1_rdata",  bus.r1_rdata,  m_rdata[1]);
    end

    // Driver tasks. Fields stay put after gnt; only req is dropped.
    task automatic wait_gnt(input bit p);
        int n;
        n = 0;
        while (n < 30) begin
            @(negedge clk); #1;
            if ((p ? bus.r1_gnt : bus.r0_gnt) === 1'b1) break;
            n++;
        end
        check($sformatf("gnt_within_budget_p%0d", p), (n < 30), 1'b1);
        if (p) bus.r1_req = 1'b0; else bus.r0_req = 1'b0;
    endtask

    task automatic do_acc(input bit p, input bit we, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk); #1;
        if (p) begin
            bus.r1_we = we; bus.r1_addr = addr; bus.r1_wdata = wd; bus.r1_req = 1'b1;
        end else begin
            bus.r0_we = we; bus.r0_addr = addr; bus.r0_wdata = wd; bus.r0_req = 1'b1;
        end
        wait_gnt(p);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int g0;
        bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0;
        bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0;
        idle_cycles(3);
        check("rst_state",   dbg_state,     2'd0);
        check("rst_r0_data", bus.r0_rdata,  32'h0);
        check("rst_r1_data", bus.r1_rdata,  32'h0);

        // 1: both request, port 0 writes; reset mid-ACCESS; port 0 wins again after release.
        rst = 1'b0;
        bus.r0_we = 1'b1; bus.r0_addr = 32'h30; bus.r0_wdata = 32'h99; bus.r0_req = 1'b1;
        bus.r1_we = 1'b0; bus.r1_addr = 32'h4;  bus.r1_req = 1'b1;
        @(negedge clk); #1;
        check("t1_first_gnt0", bus.r0_gnt, 1'b1);
        check("t1_first_gnt1", bus.r1_gnt, 1'b0);
        check("t1_we_before",  bus.mem_we, 1'b1);
        rst = 1'b1;
        #1;
        check("t1_rst_gnt0",   bus.r0_gnt,    1'b0);
        check("t1_rst_we",     bus.mem_we,    1'b0);
        check("t1_rst_rvalid", bus.r0_rvalid, 1'b0);
        check("t1_rst_mem_a",  bus.mem_a,     32'h0);
        check("t1_rst_rdata0", bus.r0_rdata,  32'h0);
        check("t1_rst_rdata1", bus.r1_rdata,  32'h0);
        @(negedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        check("t1_again_gnt0", bus.r0_gnt, 1'b1);
        check("t1_again_gnt1", bus.r1_gnt, 1'b0);
        bus.r0_req = 1'b0;
        wait_gnt(1'b1);
        idle_cycles(4);
        check("t1_r1_rdata", bus.r1_rdata, 32'h22);

        // 2: port 0 write then read of 0x10.
        we_cnt = 0; rv0_cnt = 0;
        do_acc(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        idle_cycles(4);
        check("t2_we_cycles", we_cnt,  1);
        check("t2_no_rvalid", rv0_cnt, 0);
        gq_cyc.delete(); gq_port.delete();
        do_acc(1'b0, 1'b0, 32'h10, 32'h0);
        idle_cycles(4);
        check("t2_rvalid_cnt",   rv0_cnt, 1);
        check("t2_rvalid_after", last_rv0 - gq_cyc[0], 1);
        check("t2_rdata",        bus.r0_rdata, 32'hDEADBEEF);

        // 3: contention, alternating grants 3 cycles apart.
        gq_cyc.delete(); gq_port.delete();
        fork
            begin
                do_acc(1'b0, 1'b0, 32'h0, 32'h0);
                do_acc(1'b0, 1'b0, 32'h0, 32'h0);
            end
            begin
                @(negedge clk);
                do_acc(1'b1, 1'b0, 32'h4, 32'h0);
                do_acc(1'b1, 1'b0, 32'h4, 32'h0);
            end
        join
        idle_cycles(4);
        check("t3_ngnt", gq_cyc.size(), 4);
        if (gq_cyc.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("t3_port%0d", i), gq_port[i], i % 2);
                if (i > 0) check($sformatf("t3_gap%0d", i), gq_cyc[i] - gq_cyc[i-1], 3);
            end
        end
        check("t3_r0_rdata", bus.r0_rdata, 32'h11);
        check("t3_r1_rdata", bus.r1_rdata, 32'h22);

        // 4: port 1 back-to-back writes.
        gq_cyc.delete(); gq_port.delete();
        g0 = g0_cnt;
        for (int i = 0; i < 3; i++) do_acc(1'b1, 1'b1, 32'h14 + 32'(4 * i), 32'hA0 + 32'(i));
        idle_cycles(4);
        check("t4_ngnt", gq_cyc.size(), 3);
        if (gq_cyc.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("t4_port%0d", i), gq_port[i], 1'b1);
                if (i > 0) check($sformatf("t4_gap%0d", i), gq_cyc[i] - gq_cyc[i-1], 3);
            end
        end
        check("t4_no_r0_gnt", g0_cnt - g0, 0);
        check("t4_mem_0x18", mem[6], 32'hA1);

        // 5: reset while a write is on the memory.
        do_acc(1'b0, 1'b1, 32'h20, 32'hCAFEF00D);
        check("t5_we_in_access", bus.mem_we, 1'b1);
        rst = 1'b1;
        #1;
        check("t5_we_dropped",   bus.mem_we, 1'b0);
        check("t5_gnt_dropped",  bus.r0_gnt, 1'b0);
        @(negedge clk); #1;
        rst = 1'b0;
        check("t5_mem_untouched", mem[8], 32'h0);
        rv0_cnt = 0;
        do_acc(1'b0, 1'b0, 32'h20, 32'h0);
        idle_cycles(4);
        check("t5_rdata",      bus.r0_rdata, 32'h0);
        check("t5_rvalid_cnt", rv0_cnt, 1);

        // 6: port 1 read data holds through port 0 writes.
        do_acc(1'b1, 1'b0, 32'h8, 32'h0);
        idle_cycles(2);
        check("t6_r1_read", bus.r1_rdata, 32'h55);
        do_acc(1'b0, 1'b1, 32'h24, 32'h1234);
        do_acc(1'b0, 1'b1, 32'h8,  32'h5678);
        idle_cycles(4);
        check("t6_r1_hold", bus.r1_rdata, 32'h55);
        check("t6_mem_0x8", mem[2], 32'h5678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
